// File: rtl/reg_read_port.sv
// Two-port read stage over a 32x64 register array with a one-entry
// valid/ready output buffer. Define REGREAD_BYPASS_EN for write-to-read forwarding.
module reg_read_port #(
    parameter int unsigned ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0][63:0] regs_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       addr_a,
    input  logic [4:0]       addr_b,
    input  logic             wr_en,
    input  logic [4:0]       wr_addr,
    input  logic [63:0]      wr_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      data_a,
    output logic [63:0]      data_b,
    output logic [15:0]      rd_count
);

    localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

    logic        accept;
    logic [63:0] next_a;
    logic [63:0] next_b;

    // The buffer can take a new read when it is empty or being drained this cycle.
    assign req_ready = !out_valid || out_ready;
    assign accept    = req_valid && req_ready;

    function automatic logic [63:0] read_value(input logic [4:0] addr);
        logic [63:0] value;
        value = regs_in[addr];
`ifdef REGREAD_BYPASS_EN
        if (wr_en && wr_addr == addr)
            value = wr_data;
`endif
        // The zero register wins over both the array and any forwarded write.
        if (addr == ZERO_IDX)
            value = '0;
        return value;
    endfunction

`ifndef REGREAD_BYPASS_EN
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

    // NOTE: every combinational output is assigned on every path, so no latch is inferred.
    always_comb begin
        next_a = read_value(addr_a);
        next_b = read_value(addr_b);
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            data_a    <= '0;
            data_b    <= '0;
            rd_count  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            data_a    <= next_a;
            data_b    <= next_b;
            rd_count  <= rd_count + 16'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_read_port.sv
// Scoreboard bench for reg_read_port: the driver pushes expected results on
// acceptance, a negedge monitor pops and compares on each output handshake.
module tb_reg_read_port;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0][63:0] regs_in;
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        addr_a;
    logic [4:0]        addr_b;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [63:0]       wr_data;
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       data_a;
    logic [63:0]       data_b;
    logic [15:0]       rd_count;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_count = '0;

    reg_read_port #(.ZERO_REG(31)) dut (
        .clk       (clk),
        .reset     (reset),
        .regs_in   (regs_in),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_a    (data_a),
        .data_b    (data_b),
        .rd_count  (rd_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference read of one port from the bench's view of the array.
    function automatic logic [63:0] model(input logic [4:0] addr);
        if (addr == 5'd31)
            return 64'd0;
`ifdef REGREAD_BYPASS_EN
        if (wr_en && wr_addr == addr)
            return wr_data;
`endif
        return regs_in[addr];
    endfunction

    // Issue one request; the expected result is queued at the edge that accepts it.
    task automatic send(input logic [4:0] a, input logic [4:0] b);
        exp_t e;
        bit   done;
        done      = 1'b0;
        req_valid = 1'b1;
        addr_a    = a;
        addr_b    = b;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                exp_count = exp_count + 16'd1;
                e.a   = model(a);
                e.b   = model(b);
                e.cnt = exp_count;
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        wr_en     = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: request a=%0d b=%0d not accepted in 20 cycles", a, b);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got data_a=%0h with no request pending", data_a);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("data_a", data_a, e.a);
                check("data_b", data_b, e.b);
                check("rd_count", 64'(rd_count), 64'(e.cnt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        out_ready = 1'b1;
        addr_a    = '0;
        addr_b    = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        for (int i = 0; i < 32; i++)
            regs_in[i] = {32'hA5A5_0000 | 32'(i), 32'(i * 3 + 1)};

        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_data_a", data_a, 64'd0);
        check("rst_data_b", data_b, 64'd0);
        check("rst_rd_count", 64'(rd_count), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd1);

        @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic read of two distinct registers.
        regs_in[5] = 64'd9473;
        regs_in[9] = 64'd42742;
        send(5'd5, 5'd9);
        check("first_out_valid", 64'(out_valid), 64'd1);
        idle(1);
        check("drain_clears_valid", 64'(out_valid), 64'd0);

        // Zero register ignores the array contents.
        regs_in[31] = 64'hFFFF_FFFF_FFFF_FFFF;
        send(5'd31, 5'd31);
        idle(1);

        // Same index on both ports.
        send(5'd7, 5'd7);
        idle(1);

        // Stall: output held as a snapshot while the array changes.
        regs_in[3] = 64'd69;
        out_ready  = 1'b0;
        send(5'd3, 5'd0);
        regs_in[3] = 64'd239;
        req_valid  = 1'b1;
        addr_a     = 5'd3;
        addr_b     = 5'd3;
        repeat (4) begin
            @(negedge clk);
            check("hold_data_a", data_a, 64'd69);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        out_ready = 1'b1;
        idle(1);
        check("stall_release_valid", 64'(out_valid), 64'd0);
        check("idle_keeps_data_a", data_a, 64'd69);

        // Write in the accepting cycle: forwarded only with the bypass build.
        regs_in[15] = 64'd0;
        wr_en   = 1'b1;
        wr_addr = 5'd15;
        wr_data = 64'd1239;
        send(5'd15, 5'd9);
        idle(1);
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = 64'd5;
        send(5'd31, 5'd31);
        idle(1);

        // Back-to-back reads.
        send(5'd1, 5'd2);
        send(5'd3, 5'd4);
        idle(1);

        // Reset while a result is held discards it.
        out_ready = 1'b0;
        send(5'd10, 5'd11);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_data_a", data_a, 64'd0);
        check("midrst_data_b", data_b, 64'd0);
        check("midrst_rd_count", 64'(rd_count), 64'd0);
        sb.delete();
        exp_count = '0;
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        idle(1);
        check("post_rst_no_output", 64'(out_valid), 64'd0);

        // Counter wrap with back-to-back traffic.
        while (exp_count != 16'hFFFE)
            send(5'd0, 5'd1);
        idle(1);
        check("count_fffe", 64'(rd_count), 64'hFFFE);
        send(5'd5, 5'd9);
        check("wrap_valid_1", 64'(out_valid), 64'd1);
        send(5'd31, 5'd3);
        check("wrap_valid_2", 64'(out_valid), 64'd1);
        check("count_wrapped", 64'(rd_count), 64'd0);

        idle(3);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_read_port.md
REG_READ_PORT -- requirements
Module: reg_read_port

Interface
REQ-001 SHALL have parameter ZERO_REG, default 31: register index that always reads as 64'b0.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port regs_in  input  [31:0][63:0]  current outputs of the 32x64 register array.
REQ-005 SHALL have port req_valid  input  1  read request present.
REQ-006 SHALL have port req_ready  output  1  request may be accepted this cycle.
REQ-007 SHALL have port addr_a  input  5  source register index, port A.
REQ-008 SHALL have port addr_b  input  5  source register index, port B.
REQ-009 SHALL have port wr_en  input  1  register array write strobe this cycle.
REQ-010 SHALL have port wr_addr  input  5  index written this cycle.
REQ-011 SHALL have port wr_data  input  64  value written this cycle.
REQ-012 SHALL have port out_valid  output  1  data_a/data_b hold a completed read.
REQ-013 SHALL have port out_ready  input  1  consumer takes the output this cycle.
REQ-014 SHALL have port data_a  output  64  read result, port A.
REQ-015 SHALL have port data_b  output  64  read result, port B.
REQ-016 SHALL have port rd_count  output  16  number of accepted requests, modulo 2^16.

Function
REQ-017 SHALL drive req_ready = !out_valid || out_ready, combinationally.
REQ-018 SHALL accept a request when req_valid && req_ready at a rising clk edge; results appear on data_a/data_b with out_valid=1 in the following cycle (latency 1).
REQ-019 SHALL set data_x to 64'b0 when addr_x == ZERO_REG, regardless of regs_in, wr_en, or the bypass feature.
REQ-020 SHALL otherwise set data_x to regs_in[addr_x] as sampled at the accepting edge.
REQ-021 SHALL hold data_a, data_b and out_valid stable while out_valid=1 and out_ready=0; later register writes SHALL NOT alter held data (snapshot semantics).
REQ-022 SHALL clear out_valid at an edge where out_valid && out_ready and no request is accepted.
REQ-023 SHALL, when out_valid && out_ready && req_valid at the same edge, load the new result and keep out_valid=1 (back-to-back, one read per cycle).
REQ-024 SHALL leave data_a/data_b unchanged when no request is accepted.
REQ-025 SHALL increment rd_count by 1 per accepted request, wrapping 16'hFFFF -> 16'h0000.
REQ-026 SHALL handle addr_a == addr_b, returning identical values on both ports.
REQ-027 SHALL ignore addr_x, wr_* and regs_in in cycles where no request is accepted.

Reset
REQ-028 SHALL, while reset=0, asynchronously force out_valid=0, data_a=0, data_b=0, rd_count=0.
REQ-029 SHALL discard any held or in-flight read when reset is asserted mid-operation; no output is produced for it after release.
REQ-030 SHALL accept requests starting at the first rising clk edge after reset returns to 1.

Configuration
REQ-031 SHALL use macro REGREAD_BYPASS_EN to compile write-to-read forwarding in or out.
REQ-032 SHALL, with REGREAD_BYPASS_EN defined, capture wr_data for port x when wr_en && wr_addr == addr_x && addr_x != ZERO_REG at the accepting edge.
REQ-033 SHALL, without REGREAD_BYPASS_EN, always capture regs_in[addr_x] (pre-write value), with no bypass logic present.

Verification
REQ-034 Reset=0 with out_valid=1 held -> out_valid, data_a, data_b and rd_count all read 0 immediately, before any clk edge.
REQ-035 regs_in[5]=9473, regs_in[9]=42742, request A=5, B=9, out_ready=1 -> next cycle out_valid=1, data_a=9473, data_b=42742, rd_count=1.
REQ-036 A=31, B=31, regs_in[31]=64'hFFFF_FFFF_FFFF_FFFF -> data_a=data_b=0.
REQ-037 Accept A=3 with regs_in[3]=69, out_ready=0 for 4 cycles while regs_in[3] changes to 239 -> data_a stays 69, req_ready=0 throughout; out_ready=1 with no request -> out_valid=0 next cycle.
REQ-038 regs_in[15]=0, wr_en=1, wr_addr=15, wr_data=1239, request A=15 -> data_a=1239 with REGREAD_BYPASS_EN, data_a=0 without.
REQ-039 rd_count=16'hFFFE, two back-to-back accepted requests with out_ready=1 -> rd_count=16'hFFFF then 16'h0000, out_valid=1 in both result cycles.
